// File: rtl/mux_4_1_rr_arb.sv
// mux_4_1_rr_arb
//   Round-robin arbiter that shares one 4:1 mux among four requesters.
//   Requester k owns mux input yk while it holds the grant. An owner keeps
//   the grant while it requests, for at most MAX_HOLD consecutive cycles.
//   At that limit the grant rotates if another requester is waiting.
//   Handoffs between back-to-back owners happen on a single edge, with no
//   idle cycle and no multi-hot grant.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles per owner (0 = unlimited)
//   CNT_W     hold-counter width; MAX_HOLD must be <= 2**CNT_W-1
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   req    in   [3:0] level requests; req[k] comes from requester k
//   gnt    out  [3:0] registered one-hot grant; all-zero when idle
//   s0     out  registered mux select MSB (selected index = {s0,s1})
//   s1     out  registered mux select LSB
//   valid  out  registered; 1 while a grant is active
module mux_4_1_rr_arb #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [3:0]       cur_mask;
    logic [2:0]       pick_r;

    // Rotating search: returns {found, index} for the first set bit of cand
    // met when scanning start, start+1, ... modulo 4. The scan runs from the
    // farthest offset down so the nearest candidate is written last.
    function automatic logic [2:0] pick(input logic [1:0] start,
                                        input logic [3:0] cand);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (cand[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        valid_d  = valid_q;
        cur_mask = 4'b0001 << sel_q;
        pick_r   = 3'b000;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    pick_r = pick(ptr_q, req);
                end else begin
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (req[sel_q]) begin
                    if (MAX_HOLD == 0 || hold_q < HOLD_LIM) begin
                        if (hold_q != CNT_SAT) hold_d = hold_q + 1'b1;
                    end else begin
                        // Limit reached: hand over only if someone else waits;
                        // otherwise the owner stays and the limit is re-checked
                        // every cycle with the counter parked at MAX_HOLD.
                        pick_r = pick(sel_q + 2'd1, req & ~cur_mask);
                    end
                end else if (|req) begin
                    pick_r = pick(sel_q + 2'd1, req);
                end else begin
                    // Select lines are deliberately left at the last owner.
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pick_r[2]) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << pick_r[1:0];
            sel_d   = pick_r[1:0];
            valid_d = 1'b1;
            hold_d  = {{(CNT_W-1){1'b0}}, 1'b1};
            ptr_d   = pick_r[1:0] + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            hold_q  <= '0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign s0    = sel_q[1];
    assign s1    = sel_q[0];
    assign valid = valid_q;

endmodule
